// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions for the memory / write-back stage.
// Provides the MEM-stage FSM state type, bus widths and the latency counter width.
package mem_wb_stage_pkg;

    localparam int unsigned ADDR_W = 7;   // data-memory word address width
    localparam int unsigned DATA_W = 32;  // data path width
    localparam int unsigned REG_W  = 5;   // register-file index width
    localparam int unsigned CNT_W  = 2;   // holds MEM_LAT-1 for MEM_LAT up to 3

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// EX/MEM -> MEM/WB bus.
// master: upstream pipeline (drives enable, operands and control; receives stall and WB).
// slave : mem_wb_stage (consumes the instruction in MEM; drives stall and WB).
interface mem_wb_stage_if #(
    parameter int unsigned ADDR_W = mem_wb_stage_pkg::ADDR_W,
    parameter int unsigned DATA_W = mem_wb_stage_pkg::DATA_W
);
    import mem_wb_stage_pkg::REG_W;

    logic              enableMEM;
    logic [DATA_W-1:0] ALU_RES;
    logic [ADDR_W-1:0] DIR_MEM;
    logic [DATA_W-1:0] DI_MEM;
    logic [REG_W-1:0]  rd_rt;
    logic              MemRead;
    logic              MemWrite;
    logic              RegWrite;
    logic              MemtoReg;
    logic              stall;
    logic [DATA_W-1:0] WB_data;
    logic [REG_W-1:0]  WB_rd;
    logic              WB_RegWrite;

    modport master (
        output enableMEM, ALU_RES, DIR_MEM, DI_MEM, rd_rt,
               MemRead, MemWrite, RegWrite, MemtoReg,
        input  stall, WB_data, WB_rd, WB_RegWrite
    );

    modport slave (
        input  enableMEM, ALU_RES, DIR_MEM, DI_MEM, rd_rt,
               MemRead, MemWrite, RegWrite, MemtoReg,
        output stall, WB_data, WB_rd, WB_RegWrite
    );

endinterface

// File: rtl/mem_wb_stage_mem_datos_sync.sv
// Private data memory: 2^ADDR_W x DATA_W array, synchronous write, read data
// delivered through a MEM_LAT-deep register chain.
// Ports: clk, rst (async, active-high, clears the chain only), i_en (advance chain),
//        i_we/i_addr/i_wdata (write port), o_rdata (read data, MEM_LAT cycles after address).
module mem_datos_sync #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem  [DEPTH];
    logic [DATA_W-1:0] r_pipe [MEM_LAT];

    // Storage array; intentionally not reset so contents survive a pipeline flush.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read latency chain; stage 0 samples the array, later stages just delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_en) begin
            r_pipe[0] <= r_mem[i_addr];
            for (int unsigned i = 1; i < MEM_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_rdata = r_pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage plus MEM/WB register.
// Performs stores and multi-cycle loads on a private data memory, stalls upstream
// while a load is outstanding, and registers WB data / destination / write enable.
// Ports: reloj (clock), resetMEM (async active-high reset),
//        bus (slave side of mem_wb_stage_if: EX/MEM inputs, stall and WB outputs).
module mem_wb_stage #(
    parameter int unsigned ADDR_W  = mem_wb_stage_pkg::ADDR_W,
    parameter int unsigned DATA_W  = mem_wb_stage_pkg::DATA_W,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          reloj,
    input  logic          resetMEM,
    mem_wb_stage_if.slave bus
);

    import mem_wb_stage_pkg::state_t;
    import mem_wb_stage_pkg::IDLE;
    import mem_wb_stage_pkg::RD_WAIT;
    import mem_wb_stage_pkg::REG_W;
    import mem_wb_stage_pkg::CNT_W;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0] r_wb_data, w_wb_data_nxt;
    logic [REG_W-1:0]  r_wb_rd, w_wb_rd_nxt;
    logic              r_wb_rw, w_wb_rw_nxt;
    logic              w_mem_we;
    logic [DATA_W-1:0] w_rdata;

    // Data memory with MEM_LAT read latency.
    mem_datos_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_mem (
        .clk    (reloj),
        .rst    (resetMEM),
        .i_en   (bus.enableMEM),
        .i_we   (w_mem_we),
        .i_addr (bus.DIR_MEM),
        .i_wdata(bus.DI_MEM),
        .o_rdata(w_rdata)
    );

    // State, latency counter and MEM/WB register.
    always_ff @(posedge reloj or posedge resetMEM) begin
        if (resetMEM) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wb_data <= '0;
            r_wb_rd   <= '0;
            r_wb_rw   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_wb_rd   <= w_wb_rd_nxt;
            r_wb_rw   <= w_wb_rw_nxt;
        end
    end

    // Next-state, counter, store strobe and MEM/WB next values; everything holds when disabled.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_wb_data_nxt = r_wb_data;
        w_wb_rd_nxt   = r_wb_rd;
        w_wb_rw_nxt   = r_wb_rw;
        w_mem_we      = 1'b0;

        if (bus.enableMEM) begin
            case (r_state)
                IDLE: begin
                    if (bus.MemRead && !bus.MemWrite) begin
                        // Load issued: counter runs down the remaining latency, WB gets a bubble.
                        w_state_nxt   = RD_WAIT;
                        w_cnt_nxt     = CNT_W'(MEM_LAT - 1);
                        w_wb_data_nxt = '0;
                        w_wb_rd_nxt   = '0;
                        w_wb_rw_nxt   = 1'b0;
                    end else begin
                        // ALU op or store (store wins over a simultaneous read).
                        w_mem_we      = bus.MemWrite;
                        w_wb_data_nxt = bus.ALU_RES;
                        w_wb_rd_nxt   = bus.rd_rt;
                        w_wb_rw_nxt   = bus.RegWrite;
                    end
                end
                RD_WAIT: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt     = r_cnt - CNT_W'(1);
                        w_wb_data_nxt = '0;
                        w_wb_rd_nxt   = '0;
                        w_wb_rw_nxt   = 1'b0;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_wb_data_nxt = bus.MemtoReg ? w_rdata : bus.ALU_RES;
                        w_wb_rd_nxt   = bus.rd_rt;
                        w_wb_rw_nxt   = bus.RegWrite;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Upstream hold request; reset drops it without waiting for a clock.
    assign bus.stall = !resetMEM &&
                       (((r_state == IDLE) && bus.MemRead && !bus.MemWrite) ||
                        ((r_state == RD_WAIT) && (r_cnt != '0)));

    assign bus.WB_data     = r_wb_data;
    assign bus.WB_rd       = r_wb_rd;
    assign bus.WB_RegWrite = r_wb_rw;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: one DUT per MEM_LAT value (1..3), exercised in turn.
`timescale 1ns/1ps
module tb_mem_wb_stage;

    localparam int unsigned NLAT = 3;
    localparam int unsigned AW   = 7;
    localparam int unsigned DW   = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic          rw;
    } wb_t;

    logic                     clk;
    logic                     rst;
    logic [NLAT-1:0]          en_vec;
    logic [DW-1:0]            alu_res;
    logic [DW-1:0]            di_mem;
    logic [AW-1:0]            dir_mem;
    logic [4:0]               rd_rt;
    logic                     mem_read, mem_write, reg_write, mem_to_reg;
    logic [NLAT-1:0]          o_stall;
    logic [NLAT-1:0]          o_rw;
    logic [NLAT-1:0][DW-1:0]  o_data;
    logic [NLAT-1:0][4:0]     o_rd;

    int  checks;
    int  failures;
    int  cur;
    bit  mon_on;
    bit  q_stall[$];
    wb_t q_wb[$];

    // Reference model: word memory plus list of addresses holding defined data.
    logic [DW-1:0] mdl_mem [128];
    int            wlist[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NLAT; g++) begin : g_lat
        mem_wb_stage_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        assign bus.enableMEM = en_vec[g];
        assign bus.ALU_RES   = alu_res;
        assign bus.DIR_MEM   = dir_mem;
        assign bus.DI_MEM    = di_mem;
        assign bus.rd_rt     = rd_rt;
        assign bus.MemRead   = mem_read;
        assign bus.MemWrite  = mem_write;
        assign bus.RegWrite  = reg_write;
        assign bus.MemtoReg  = mem_to_reg;
        assign o_stall[g]    = bus.stall;
        assign o_data[g]     = bus.WB_data;
        assign o_rd[g]       = bus.WB_rd;
        assign o_rw[g]       = bus.WB_RegWrite;

        mem_wb_stage #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g + 1)) dut (
            .reloj   (clk),
            .resetMEM(rst),
            .bus     (bus)
        );
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (MEM_LAT=%0d) t=%0t: got 0x%08h expected 0x%08h",
                     name, cur + 1, $time, act, exp);
        end
    endtask

    task automatic set_nop();
        alu_res = '0; di_mem = '0; dir_mem = '0; rd_rt = '0;
        mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    endtask

    // Present one instruction, holding it for its whole occupancy. frz_len cycles with
    // enable low are inserted before the frz_at-th enabled cycle.
    task automatic issue(input bit rd_op, input bit wr_op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] alu,
                         input logic [4:0] rd, input bit rw, input bit m2r,
                         input int frz_at, input int frz_len);
        bit  is_load = rd_op && !wr_op;
        int  lat     = cur + 1;
        int  n_en    = is_load ? lat + 1 : 1;
        int  en_idx  = 0;
        bit  en;
        wb_t w;
        mem_read = rd_op; mem_write = wr_op; dir_mem = addr; di_mem = wdata;
        alu_res = alu; rd_rt = rd; reg_write = rw; mem_to_reg = m2r;
        for (int c = 0; c < n_en + frz_len; c++) begin
            en = !(c >= frz_at && c < frz_at + frz_len);
            q_stall.push_back(is_load && en_idx < lat);
            en_vec      = '0;
            en_vec[cur] = en;
            if (en) begin
                if (is_load && en_idx < lat) begin
                    w = '0;
                end else begin
                    w.data = (is_load && m2r) ? mdl_mem[addr] : alu;
                    w.rd   = rd;
                    w.rw   = rw;
                end
                q_wb.push_back(w);
                if (wr_op) begin
                    mdl_mem[addr] = wdata;
                    wlist.push_back(int'(addr));
                end
                en_idx++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        #2;
        chk("stall_queue_empty", DW'(q_stall.size()), '0);
        chk("wb_queue_empty", DW'(q_wb.size()), '0);
        mon_on = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; en_vec = '0; set_nop();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", DW'(o_stall[cur]), '0);
        chk("reset_wb_data", o_data[cur], '0);
        chk("reset_wb_rd", DW'(o_rd[cur]), '0);
        chk("reset_wb_regwrite", DW'(o_rw[cur]), '0);
        rst = 1'b0;
    endtask

    // Abort a load in RD_WAIT with an asynchronous reset pulse.
    task automatic reset_mid_load();
        mem_read = 1'b1; mem_write = 1'b0; dir_mem = 7'h12; rd_rt = 5'd8;
        reg_write = 1'b1; mem_to_reg = 1'b1; alu_res = 32'h0BAD_0BAD;
        en_vec = '0; en_vec[cur] = 1'b1;
        @(posedge clk); #1;
        chk("rd_wait_stall", DW'(o_stall[cur]), DW'(cur > 0));
        #2 rst = 1'b1;
        #1;
        chk("abort_stall", DW'(o_stall[cur]), '0);
        chk("abort_wb_data", o_data[cur], '0);
        chk("abort_wb_rd", DW'(o_rd[cur]), '0);
        chk("abort_wb_regwrite", DW'(o_rw[cur]), '0);
        @(posedge clk); #1;
        rst = 1'b0; set_nop(); en_vec = '0;
    endtask

    // Monitor: per cycle compare stall; after each enabled edge compare the MEM/WB register.
    initial begin : monitor
        logic en_s;
        bit   exp_s;
        wb_t  e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                en_s = en_vec[cur];
                if (q_stall.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL stall_queue_underflow (MEM_LAT=%0d) t=%0t", cur + 1, $time);
                end else begin
                    exp_s = q_stall.pop_front();
                    chk("stall", DW'(o_stall[cur]), DW'(exp_s));
                end
                @(posedge clk); #1;
                if (en_s) begin
                    if (q_wb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wb_queue_underflow (MEM_LAT=%0d) t=%0t", cur + 1, $time);
                    end else begin
                        e = q_wb.pop_front();
                        chk("wb_data", o_data[cur], e.data);
                        chk("wb_rd", DW'(o_rd[cur]), DW'(e.rd));
                        chk("wb_regwrite", DW'(o_rw[cur]), DW'(e.rw));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

    initial begin : driver
        int            op;
        int            fa, fl;
        logic [AW-1:0] a;
        checks = 0; failures = 0; cur = 0; mon_on = 1'b0;
        rst = 1'b1; en_vec = '0; set_nop();
        for (int l = 0; l < NLAT; l++) begin
            cur = l;
            wlist.delete();
            do_reset();
            mon_on = 1'b1;
            issue(0, 0, 7'h00, 32'h0,         32'h0000_00AA, 5'd5,  1, 0, 0, 0);
            issue(0, 1, 7'h12, 32'hDEAD_BEEF, 32'h0000_1111, 5'd0,  0, 0, 0, 0);
            issue(1, 0, 7'h12, 32'h0,         32'h0000_2222, 5'd8,  1, 1, 0, 0);
            issue(1, 1, 7'h7F, 32'h0000_1234, 32'h0000_3333, 5'd3,  1, 0, 0, 0);
            issue(1, 0, 7'h7F, 32'h0,         32'h0000_4444, 5'd9,  1, 1, 0, 0);
            issue(1, 0, 7'h12, 32'h0,         32'h0000_5555, 5'd10, 1, 1, 1, 3);
            issue(1, 0, 7'h12, 32'h0,         32'h0000_6666, 5'd11, 1, 0, 0, 0);
            drain();
            reset_mid_load();
            mon_on = 1'b1;
            issue(1, 0, 7'h12, 32'h0, 32'h0000_7777, 5'd12, 1, 1, 0, 0);
            for (int k = 0; k < 40; k++) begin
                op = int'($urandom_range(0, 3));
                fa = 0; fl = 0;
                if ($urandom_range(0, 7) == 0) begin
                    fl = int'($urandom_range(1, 3));
                    fa = int'($urandom_range(0, 1));
                end
                case (op)
                    0: issue(0, 0, AW'($urandom), $urandom, $urandom, 5'($urandom),
                             1'($urandom), 1'($urandom), fa, fl);
                    1: issue(1'($urandom), 1, AW'($urandom), $urandom, $urandom, 5'($urandom),
                             1'($urandom), 1'($urandom), fa, fl);
                    default: begin
                        a = AW'(wlist[$urandom_range(0, wlist.size() - 1)]);
                        issue(1, 0, a, $urandom, $urandom, 5'($urandom),
                              1'($urandom), 1'($urandom), fa, fl);
                    end
                endcase
            end
            drain();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
